// File: rtl/sign_mag_accum_pkg.sv
// Shared types and default widths for the sign-magnitude frame accumulator.
package sign_mag_accum_pkg;

    localparam int unsigned DEF_IN_W      = 5;
    localparam int unsigned DEF_ACC_W     = 8;
    localparam int unsigned DEF_N_SAMPLES = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/sign_mag_accum_if.sv
// Operand-in / result-out handshake bundle of the sign-magnitude accumulator.
interface sign_mag_accum_if
    import sign_mag_accum_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned ACC_W = DEF_ACC_W
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/sm_sat_add.sv
// Combinational sign-magnitude adder; saturates the magnitude and flags it.
module sm_sat_add
    import sign_mag_accum_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);
    localparam int unsigned MAG_W = ACC_W - 1;

    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;
    logic             sgn_a;
    logic             sgn_b;
    logic [MAG_W:0]   raw;
    logic [MAG_W-1:0] mag_r;
    logic             sgn_r;

    always_comb begin
        mag_a = a[MAG_W-1:0];
        mag_b = b[MAG_W-1:0];
        // -0 behaves exactly like +0
        sgn_a = a[ACC_W-1] & (mag_a != '0);
        sgn_b = b[ACC_W-1] & (mag_b != '0);
        raw   = '0;
        mag_r = '0;
        sgn_r = 1'b0;
        sat   = 1'b0;
        if (sgn_a == sgn_b) begin
            raw   = {1'b0, mag_a} + {1'b0, mag_b};
            sgn_r = sgn_a;
            if (raw[MAG_W]) begin
                mag_r = '1;
                sat   = 1'b1;
            end else begin
                mag_r = raw[MAG_W-1:0];
            end
        end else if (mag_a >= mag_b) begin
            mag_r = mag_a - mag_b;
            sgn_r = sgn_a;
        end else begin
            mag_r = mag_b - mag_a;
            sgn_r = sgn_b;
        end
        sum = {sgn_r & (mag_r != '0), mag_r};
    end

endmodule

// File: rtl/sign_mag_accum.sv
// Accumulates N_SAMPLES sign-magnitude operands per frame and holds the total
// until the downstream side takes it.
module sign_mag_accum
    import sign_mag_accum_pkg::*;
#(
    parameter int unsigned IN_W      = DEF_IN_W,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned N_SAMPLES = DEF_N_SAMPLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    sign_mag_accum_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(N_SAMPLES + 1);

    state_e           state_q;
    state_e           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [ACC_W-1:0] operand_c;
    logic [ACC_W-1:0] sum_c;
    logic             sat_c;

    // Widen the operand: magnitude in the low bits, sign moved to the MSB
    always_comb begin
        operand_c              = '0;
        operand_c[IN_W-2:0]    = bus.in_data[IN_W-2:0];
        operand_c[ACC_W-1]     = bus.in_data[IN_W-1];
    end

    sm_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a   (acc_q),
        .b   (operand_c),
        .sum (sum_c),
        .sat (sat_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: clear beats everything, including a same-cycle operand
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_d = sum_c;
                        ovf_d = ovf_q | sat_c;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = acc_q;
    assign bus.out_ovf   = ovf_q;

endmodule
